// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle controller and its datapath:
// opcodes, ALU operations, PC source selects and FSM states.
package multicycle_control_unit_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EXE_ALU = 4'd2,
      S_EXE_BR  = 4'd3,
      S_EXE_MEM = 4'd4,
      S_MEM     = 4'd5,
      S_WB_ALU  = 4'd6,
      S_WB_LW   = 4'd7,
      S_HALT    = 4'd8
   } state_e;

   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
             (op == OP_AND) || (op == OP_SLT);
   endfunction

   function automatic logic is_alu(input logic [5:0] op);
      return is_rtype(op) || (op == OP_ADDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational control decode: (state, opcode, flags) to datapath enables.
// Opcode-only selects stay valid for the whole instruction.
module mcu_output_decode
   import multicycle_control_unit_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_wre,
   output logic       ir_wre,
   output logic       reg_wre,
   output logic       reg_dst,
   output logic       db_data_src,
   output logic       alu_src_b,
   output logic [2:0] alu_op,
   output logic       ext_sel,
   output logic [1:0] pc_src,
   output logic       m_rd,
   output logic       m_wr,
   output logic       halted
);

   logic legal;

   always_comb begin
      legal       = is_alu(opcode) || (opcode == OP_SW) ||
                    (opcode == OP_LW) || (opcode == OP_BEQ) ||
                    (opcode == OP_J) || (opcode == OP_HALT);
      pc_wre      = 1'b0;
      ir_wre      = 1'b0;
      reg_wre     = 1'b0;
      db_data_src = 1'b0;
      pc_src      = PC_SEQ;
      m_rd        = 1'b0;
      m_wr        = 1'b0;
      halted      = 1'b0;
      reg_dst     = is_rtype(opcode);
      alu_src_b   = (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                    (opcode == OP_SW) || (opcode == OP_LW);
      ext_sel     = (opcode != OP_ORI);
      alu_op      = ALU_ADD;
      unique case (opcode)
         OP_BEQ, OP_SUB: alu_op = ALU_SUB;
         OP_OR, OP_ORI:  alu_op = ALU_OR;
         OP_AND:         alu_op = ALU_AND;
         OP_SLT:         alu_op = ALU_SLT;
         default:        alu_op = ALU_ADD;
      endcase
      unique case (state)
         S_IF: ir_wre = 1'b1;
         S_ID: begin
            if (opcode == OP_J) begin
               pc_wre = 1'b1;
               pc_src = PC_JMP;
            end else if (!legal) begin
               pc_wre = 1'b1;
            end
         end
         S_EXE_BR: begin
            pc_wre = 1'b1;
            if (zero) pc_src = PC_BR;
         end
         S_MEM: begin
            m_rd = (opcode == OP_LW);
            m_wr = (opcode == OP_SW);
            pc_wre = (opcode == OP_SW) && mem_ready;
         end
         S_WB_ALU: begin
            pc_wre  = 1'b1;
            reg_wre = 1'b1;
         end
         S_WB_LW: begin
            pc_wre      = 1'b1;
            reg_wre     = 1'b1;
            db_data_src = 1'b1;
         end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: state register, retired-instruction counter
// and the enable gating applied while reset is held.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWre,
   output logic             IRWre,
   output logic             RegWre,
   output logic             RegDst,
   output logic             DBDataSrc,
   output logic             ALUSrcB,
   output logic [2:0]       ALUOp,
   output logic             ExtSel,
   output logic [1:0]       PCSrc,
   output logic             mRD,
   output logic             mWR,
   output logic             halted,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pc_wre, ir_wre, reg_wre, m_rd, m_wr;

   mcu_output_decode u_dec (
      .state       (state_q),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pc_wre      (pc_wre),
      .ir_wre      (ir_wre),
      .reg_wre     (reg_wre),
      .reg_dst     (RegDst),
      .db_data_src (DBDataSrc),
      .alu_src_b   (ALUSrcB),
      .alu_op      (ALUOp),
      .ext_sel     (ExtSel),
      .pc_src      (PCSrc),
      .m_rd        (m_rd),
      .m_wr        (m_wr),
      .halted      (halted)
   );

   // Reset forces IF, but its decode must not fire until reset releases.
   assign PCWre  = pc_wre & RST;
   assign IRWre  = ir_wre & RST;
   assign RegWre = reg_wre & RST;
   assign mRD    = m_rd & RST;
   assign mWR    = m_wr & RST;

   assign state       = state_q;
   assign instr_count = cnt_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, PCWre};
      unique case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            if (opcode == OP_J)                           state_d = S_IF;
            else if (opcode == OP_HALT)                   state_d = S_HALT;
            else if (opcode == OP_BEQ)                    state_d = S_EXE_BR;
            else if (opcode == OP_SW || opcode == OP_LW)  state_d = S_EXE_MEM;
            else if (is_alu(opcode))                      state_d = S_EXE_ALU;
            else                                          state_d = S_IF;
         end
         S_EXE_ALU: state_d = S_WB_ALU;
         S_EXE_BR:  state_d = S_IF;
         S_EXE_MEM: state_d = S_MEM;
         S_MEM: begin
            if (mem_ready)
               state_d = (opcode == OP_LW) ? S_WB_LW : S_IF;
         end
         S_WB_ALU: state_d = S_IF;
         S_WB_LW:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multi-cycle controller: walks each instruction
// class phase by phase against hand-derived control values.
module tb_multicycle_control_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        PCWre, IRWre, RegWre, RegDst, DBDataSrc, ALUSrcB;
   logic [2:0]  ALUOp;
   logic        ExtSel;
   logic [1:0]  PCSrc;
   logic        mRD, mWR, halted;
   logic [3:0]  state;
   logic [31:0] instr_count;

   int errors = 0;
   int checks = 0;

   multicycle_control_unit #(.CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .PCWre(PCWre), .IRWre(IRWre),
      .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
      .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR), .halted(halted),
      .state(state), .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
      #12;
      chk("rst_state", state, 4'd0);
      chk("rst_en", {PCWre, IRWre, RegWre, mRD, mWR}, 5'b0);
      chk("rst_cnt", instr_count, 32'd0);
      chk("rst_halt", halted, 1'b0);
      RST = 1'b1; #1;
      chk("add_if", {state, IRWre}, {4'd0, 1'b1});
      tick();
      chk("add_id", {state, PCWre, IRWre}, {4'd1, 2'b00});
      tick();
      chk("add_exe", {state, RegWre, ALUOp}, {4'd2, 1'b0, 3'b000});
      tick();
      chk("add_wb", {state, RegWre, RegDst, DBDataSrc, PCWre},
          {4'd6, 4'b1101});
      tick();
      chk("add_cnt", {state, instr_count}, {4'd0, 32'd1});

      opcode = 6'b110001; #1;
      tick();
      chk("lw_id", state, 4'd1);
      tick();
      chk("lw_exe", {state, ALUSrcB, mRD}, {4'd4, 2'b10});
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lw_mem_wait", {state, mRD, mWR, PCWre}, {4'd5, 3'b100});
      end
      tick();
      mem_ready = 1'b1; #1;
      chk("lw_mem_rdy", {state, mRD, PCWre, RegWre}, {4'd5, 3'b100});
      tick();
      mem_ready = 1'b0; #1;
      chk("lw_wb", {state, RegWre, RegDst, DBDataSrc, PCWre},
          {4'd7, 4'b1011});
      tick();
      chk("lw_cnt", {state, instr_count}, {4'd0, 32'd2});

      opcode = 6'b110100; zero = 1'b1; #1;
      tick();
      tick();
      chk("beq_t", {state, PCSrc, PCWre, RegWre, ALUOp},
          {4'd3, 2'b01, 2'b10, 3'b001});
      tick();
      zero = 1'b0; #1;
      tick();
      tick();
      chk("beq_nt", {state, PCSrc, PCWre, RegWre}, {4'd3, 2'b00, 2'b10});
      tick();
      chk("beq_cnt", {state, instr_count}, {4'd0, 32'd4});

      opcode = 6'b111000; #1;
      tick();
      chk("j_id", {state, PCWre, PCSrc}, {4'd1, 1'b1, 2'b10});
      tick();
      chk("j_if", {state, instr_count}, {4'd0, 32'd5});

      opcode = 6'b101010; #1;
      tick();
      chk("ill_id", {state, PCWre, RegWre, PCSrc}, {4'd1, 2'b10, 2'b00});
      tick();
      chk("ill_if", {state, instr_count}, {4'd0, 32'd6});

      opcode = 6'b110000; #1;
      tick();
      tick();
      tick();
      chk("sw_mem", {state, mWR, mRD, ALUSrcB}, {4'd5, 3'b101});
      RST = 1'b0; #1;
      chk("sw_rst", {state, mWR, IRWre, instr_count},
          {4'd0, 2'b00, 32'd0});
      RST = 1'b1; #1;

      opcode = 6'b010010; #1;
      tick();
      chk("ori_id", {ExtSel, ALUSrcB, ALUOp, RegDst},
          {2'b01, 3'b010, 1'b0});
      tick();
      tick();
      chk("ori_wb", {state, RegWre, RegDst}, {4'd6, 2'b10});
      tick();

      opcode = 6'b111111; #1;
      tick();
      chk("halt_id", PCWre, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         mem_ready = i[0]; #1;
         chk("halt_hold", {state, halted, PCWre, IRWre, RegWre, mRD, mWR,
             instr_count}, {4'd8, 6'b100000, 32'd1});
      end
      RST = 1'b0; #1;
      chk("halt_rst", {state, halted}, {4'd0, 1'b0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
